// File: rtl/fetch_unit.sv
// Fetch stage: program counter plus instruction register feeding decode/execute.
// Handles stall, execute-driven redirects with wrong-path flush, a sticky
// out-of-range jump flag and a saturating count of delivered instructions.
module fetch_unit #(
  parameter int unsigned         ADDR_W  = 6,
  parameter int unsigned         INS_W   = 13,
  parameter logic [INS_W-1:0]    NOP_INS = '0,
  parameter int unsigned         CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [INS_W-1:0]  ins_in,
  input  logic              jmp_req,
  input  logic [7:0]        jmp_addr,
  output logic [ADDR_W-1:0] pc_addr,
  output logic [INS_W-1:0]  ir_out,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid,
  output logic              addr_err,
  output logic [CNT_W-1:0]  fetch_cnt
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [INS_W-1:0]  ir_q, ir_d;
  logic [ADDR_W-1:0] ir_pc_q, ir_pc_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Next-state selection: a jump beats a stall, a stall holds everything.
  always_comb begin
    pc_d    = pc_q;
    ir_d    = ir_q;
    ir_pc_d = ir_pc_q;
    valid_d = valid_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    if (jmp_req) begin
      pc_d    = jmp_addr[ADDR_W-1:0];
      // The word on ins_in belongs to the wrong path; replace it with a bubble.
      ir_d    = NOP_INS;
      valid_d = 1'b0;
      if (|jmp_addr[7:ADDR_W]) begin
        err_d = 1'b1;
      end
    end else if (en) begin
      ir_d    = ins_in;
      ir_pc_d = pc_q;
      valid_d = 1'b1;
      pc_d    = pc_q + 1'b1;
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State registers with synchronous reset taking priority over all inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= '0;
      ir_q    <= NOP_INS;
      ir_pc_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ir_pc_q <= ir_pc_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are driven straight from registers.
  always_comb begin
    pc_addr   = pc_q;
    ir_out    = ir_q;
    ir_pc     = ir_pc_q;
    ir_valid  = valid_q;
    addr_err  = err_q;
    fetch_cnt = cnt_q;
  end

endmodule
